qgpio_port: RTL



---
 rtl/qgpio_port_pkg.sv | 21 ++
 rtl/qgpio_debounce.sv | 60 ++++++
 rtl/qgpio_port.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/qgpio_port_pkg.sv
// Shared definitions for the qgpio_port block: register indices, widths and
// the register-port FSM state encoding.
package qgpio_port_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 8;

    localparam logic [ADDR_W-1:0] REG_DATA_OUT   = 3'd0;
    localparam logic [ADDR_W-1:0] REG_OE         = 3'd1;
    localparam logic [ADDR_W-1:0] REG_DATA_IN    = 3'd2;
    localparam logic [ADDR_W-1:0] REG_IRQ_EN     = 3'd3;
    localparam logic [ADDR_W-1:0] REG_IRQ_STATUS = 3'd4;
    localparam logic [ADDR_W-1:0] REG_EDGE_SEL   = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/qgpio_debounce.sv
// Per-pin input conditioning: 2-flop synchronizer, counter debouncer and
// rise/fall pulses that coincide with the edge at which stable_o changes.
// Ports: clk/rst (sync, active-high), pin_i async pin, stable_o debounced
// level, rise_c/fall_c combinational pulses (high in the cycle before the
// edge at which stable_o flips).
module qgpio_debounce
    import qgpio_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_c,
    output logic fall_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter runs only while the synchronized input disagrees with the
    // debounced level; reaching CNT_MAX commits the new level.
    always_comb begin
        sync1_d  = pin_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q + CNT_W'(1) == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_c   = stable_d & ~stable_q;
    assign fall_c   = ~stable_d & stable_q;

endmodule

// File: rtl/qgpio_port.sv
// GPIO port: per-pin debounced inputs with edge interrupts, software output
// value/enable, and a single-outstanding request/response register port.
// Ports: clk/rst (sync, active-high); gpio_in async pins; gpio_out/gpio_oe
// registered pin drive; req_* request channel; rsp_* response channel;
// irq = OR of enabled interrupt status bits.
module qgpio_port
    import qgpio_port_pkg::*;
#(
    parameter int unsigned NUM_PINS        = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic [NUM_PINS-1:0] gpio_out,
    output logic [NUM_PINS-1:0] gpio_oe,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [REG_W-1:0]    req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [REG_W-1:0]    rsp_rdata,
    output logic                irq
);

    logic [NUM_PINS-1:0] data_in, rise_c, fall_c, event_c, w1c_c, wdata_pins;
    logic [NUM_PINS-1:0] data_out_q, data_out_d;
    logic [NUM_PINS-1:0] oe_q, oe_d;
    logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
    logic [NUM_PINS-1:0] irq_status_q, irq_status_d;
    logic [NUM_PINS-1:0] edge_sel_q, edge_sel_d;
    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [REG_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [REG_W-1:0]    rdata_c;
    logic                accept_c;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        qgpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .pin_i   (gpio_in[i]),
            .stable_o(data_in[i]),
            .rise_c  (rise_c[i]),
            .fall_c  (fall_c[i])
        );
    end

    assign wdata_pins = req_wdata[NUM_PINS-1:0];
    assign accept_c   = req_valid & req_ready_q;
    // EDGE_SEL is taken from the flop, so a write only affects later edges.
    assign event_c    = (rise_c & edge_sel_q) | (fall_c & ~edge_sel_q);

    // Read mux over register contents before the accept edge.
    always_comb begin
        rdata_c = '0;
        case (req_addr)
            REG_DATA_OUT:   rdata_c = REG_W'(data_out_q);
            REG_OE:         rdata_c = REG_W'(oe_q);
            REG_DATA_IN:    rdata_c = REG_W'(data_in);
            REG_IRQ_EN:     rdata_c = REG_W'(irq_en_q);
            REG_IRQ_STATUS: rdata_c = REG_W'(irq_status_q);
            REG_EDGE_SEL:   rdata_c = REG_W'(edge_sel_q);
            default:        rdata_c = '0;
        endcase
    end

    // Register writes, W1C status (new events win over clears) and port FSM.
    always_comb begin
        data_out_d  = data_out_q;
        oe_d        = oe_q;
        irq_en_d    = irq_en_q;
        edge_sel_d  = edge_sel_q;
        w1c_c       = '0;
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;

        if (accept_c && req_write) begin
            case (req_addr)
                REG_DATA_OUT:   data_out_d = wdata_pins;
                REG_OE:         oe_d       = wdata_pins;
                REG_IRQ_EN:     irq_en_d   = wdata_pins;
                REG_IRQ_STATUS: w1c_c      = wdata_pins;
                REG_EDGE_SEL:   edge_sel_d = wdata_pins;
                default:        ;
            endcase
        end

        irq_status_d = (irq_status_q & ~w1c_c) | event_c;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d     = RESP;
                    rsp_rdata_d = req_write ? '0 : rdata_c;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            oe_q         <= '0;
            irq_en_q     <= '0;
            irq_status_q <= '0;
            edge_sel_q   <= '0;
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            data_out_q   <= data_out_d;
            oe_q         <= oe_d;
            irq_en_q     <= irq_en_d;
            irq_status_q <= irq_status_d;
            edge_sel_q   <= edge_sel_d;
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign gpio_out  = data_out_q;
    assign gpio_oe   = oe_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign irq       = |(irq_status_q & irq_en_q);

endmodule
